// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] FETCH_NOP_WORD = 16'h0000;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, pc} buffer absorbing a fetched word during a decode stall
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  output logic                   full,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  logic                   full_q, full_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;

  // clear wins over push so a redirect never leaves a stale word behind
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      instr_d = push_instr;
      pc_d    = push_pc;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch front end: PC, imem req/ack, skid buffer, redirect squash
// Optional bubble counter output enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 16,
  parameter int unsigned             RESET_PC   = FETCH_RESET_PC,
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD   = FETCH_NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [INSTR_WIDTH-1:0] instruction_r,
  output logic [ADDR_WIDTH-1:0]  pc_r,
  output logic                   valid_r
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            bubble_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC = 1;

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic                   req_q, req_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_r_q, pc_r_d;
  logic                   valid_q, valid_d;

  logic                   ack_v;
  logic                   skid_push, skid_pop, skid_clear, skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  assign ack_v = imem_ack & req_q;

  fetch_skid_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .push_instr (imem_rdata),
    .push_pc    (pc_q),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    pc_r_d     = pc_r_q;
    valid_d    = valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (redirect) begin
      instr_d    = NOP_WORD;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      target_d   = redirect_pc;
      // an unanswered request must be drained before the new address can go out
      if (ack_v || !req_q) begin
        pc_d    = redirect_pc;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DRAIN;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (ack_v) begin
            pc_d = pc_q + PC_INC;
            if (stall) begin
              skid_push = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              instr_d = imem_rdata;
              pc_r_d  = pc_q;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_d  = skid_full ? skid_instr : NOP_WORD;
            pc_r_d   = skid_pc;
            valid_d  = skid_full;
            skid_pop = 1'b1;
            state_d  = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (ack_v) begin
            pc_d    = target_q;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end

    // registered request: low out of reset, low while holding a skid word
    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= ADDR_WIDTH'(RESET_PC);
      target_q <= '0;
      req_q    <= 1'b0;
      instr_q  <= NOP_WORD;
      pc_r_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      pc_r_q   <= pc_r_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instruction_r = instr_q;
  assign pc_r          = pc_r_q;
  assign valid_r       = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!valid_q && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
